// File: rtl/pheap_level_pkg.sv
// Shared pHeap types: slot entry, opcodes, level handshake status and per-level capacity.
package pheap_level_pkg;
  localparam int LEVELS = 3;

  typedef struct packed {
    logic [31:0]       priorityValue;
    logic [LEVELS-1:0] capacity;
    logic              active;
  } entry_t;

  typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;

  typedef enum logic [1:0] {DONE = 2'd0, WAIT = 2'd1, NEXT_LEVEL = 2'd2} done_t;

  // Number of free places in the subtree rooted at one slot of level l.
  function automatic logic [LEVELS-1:0] levelCap(input int l);
    levelCap = LEVELS'((1 << (LEVELS - l + 1)) - 1);
  endfunction
endpackage

// File: rtl/pheap_level_if.sv
// Level handoff bundle: op from the level above, pair read for it, pair read of the level below.
interface pheap_level_if #(parameter int LEVEL = 2);
  import pheap_level_pkg::*;
  localparam int SW = LEVEL - 1;
  localparam int PW = (SW > 1) ? SW - 1 : 1;

  logic          start;
  opcode_t       op;
  logic [31:0]   in;
  logic [SW-1:0] posIn;
  logic [PW-1:0] raddrTop;
  entry_t        rTopL, rTopR;
  entry_t        rBotL, rBotR;
  logic [SW-1:0] raddrBot;
  done_t         done;
  logic [31:0]   out;
  logic [SW:0]   posOut;
  logic          err;

  modport master (output start, op, in, posIn, raddrTop, rBotL, rBotR,
                  input  rTopL, rTopR, raddrBot, done, out, posOut, err);
  modport slave  (input  start, op, in, posIn, raddrTop, rBotL, rBotR,
                  output rTopL, rTopR, raddrBot, done, out, posOut, err);
endinterface

// File: rtl/pheap_level_mem.sv
// Slot memory of one level: one write port, registered slot read and pair read, write-first.
module pheap_level_mem
  import pheap_level_pkg::*;
#(
  parameter  int LEVEL = 2,
  localparam int SW    = LEVEL - 1,
  localparam int PW    = (SW > 1) ? SW - 1 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [SW-1:0] saddr,
  output entry_t        sdata,
  input  logic [PW-1:0] paddr,
  output entry_t        pl,
  output entry_t        pr
);
  localparam int     N     = 2 ** SW;
  localparam entry_t RST_E = '{priorityValue: 32'd0, capacity: levelCap(LEVEL), active: 1'b0};

  entry_t        mem [N];
  logic [SW-1:0] li, ri;

  assign li = SW'({paddr, 1'b0});
  assign ri = SW'({paddr, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= RST_E;
      sdata <= RST_E;
      pl    <= RST_E;
      pr    <= RST_E;
    end else begin
      if (we) mem[waddr] <= wdata;
      sdata <= (we && waddr == saddr) ? wdata : mem[saddr];
      pl    <= (we && waddr == li)    ? wdata : mem[li];
      pr    <= (we && waddr == ri)    ? wdata : mem[ri];
    end
  end
endmodule

// File: rtl/pheap_level.sv
// Non-root pHeap level: LEQ/DEQ on one slot, start at t -> result in t+2, forwards via NEXT_LEVEL.
// PHEAP_OVF_DETECT_EN adds a sticky err on LEQ into a full slot or DEQ from an empty one.
module pheap_level
  import pheap_level_pkg::*;
#(
  parameter int LEVEL = 2,
  parameter bit LAST  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  pheap_level_if.slave  lv
);
  localparam int                SW  = LEVEL - 1;
  localparam logic [LEVELS-1:0] CAP = levelCap(LEVEL);

  typedef enum logic [1:0] {IDLE, READ, EXEC} state_t;
  state_t state, state_nx;

  opcode_t           op_q;
  logic [31:0]       in_q, out_q, out_nx;
  logic [SW-1:0]     pos_q, raddr;
  logic [SW:0]       posout_q;
  entry_t            rs, bl, br, wdata_q, wdata_nx;
  done_t             done_q, done_nx;
  logic              end_nx, take, pick_r;
  logic [LEVELS-1:0] cap_dec, cap_inc;

  // The slot and the child pair must be addressed in the start cycle to land in READ.
  assign take         = (state == IDLE) && lv.start;
  assign raddr        = take ? lv.posIn : pos_q;
  assign lv.raddrBot  = raddr;
  assign lv.out       = out_q;
  assign lv.posOut    = posout_q;

  assign bl = LAST ? '0 : lv.rBotL;
  assign br = LAST ? '0 : lv.rBotR;

  pheap_level_mem #(.LEVEL(LEVEL)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (state == EXEC),
    .waddr (pos_q),
    .wdata (wdata_q),
    .saddr (raddr),
    .sdata (rs),
    .paddr (lv.raddrTop),
    .pl    (lv.rTopL),
    .pr    (lv.rTopR)
  );

`ifdef PHEAP_OVF_DETECT_EN
  logic ovf, err_q;
  assign ovf    = (op_q == LEQ) ? (rs.active && rs.capacity == '0) : !rs.active;
  assign lv.err = err_q;
  always_ff @(posedge clk) begin
    if (rst)                        err_q <= 1'b0;
    else if (state == READ && ovf)  err_q <= 1'b1;
  end
`else
  assign lv.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lv.done  = DONE;
    case (state)
      IDLE: if (lv.start) state_nx = READ;
      READ: begin state_nx = EXEC; lv.done = WAIT; end
      EXEC: begin state_nx = IDLE; lv.done = done_q; end
      default: state_nx = IDLE;
    endcase
  end

  // Result is resolved from the READ-cycle samples and replayed during EXEC.
  always_comb begin
    wdata_nx = rs;
    done_nx  = DONE;
    out_nx   = out_q;
    end_nx   = 1'b0;
    pick_r   = 1'b0;
    cap_dec  = (rs.capacity == '0) ? '0 : rs.capacity - LEVELS'(1);
    cap_inc  = (rs.capacity >= CAP) ? CAP : rs.capacity + LEVELS'(1);
    if (op_q == LEQ) begin
      wdata_nx.capacity = cap_dec;
      wdata_nx.active   = 1'b1;
      if (!rs.active) begin
        wdata_nx.priorityValue = in_q;
        out_nx                 = in_q;
      end else begin
        wdata_nx.priorityValue = (in_q > rs.priorityValue) ? in_q : rs.priorityValue;
        out_nx                 = (in_q > rs.priorityValue) ? rs.priorityValue : in_q;
        if (bl.capacity != '0 && br.capacity != '0)
          end_nx = (bl.priorityValue <= br.priorityValue) ? 1'b0 : 1'b1;
        else
          end_nx = (bl.capacity != '0) ? 1'b0 : 1'b1;
        done_nx = LAST ? DONE : NEXT_LEVEL;
      end
    end else begin
      out_nx            = rs.priorityValue;
      wdata_nx.capacity = cap_inc;
      if (!bl.active && !br.active) begin
        wdata_nx.priorityValue = 32'd0;
        wdata_nx.active        = 1'b0;
      end else begin
        pick_r                 = !bl.active || (br.active && br.priorityValue > bl.priorityValue);
        wdata_nx.priorityValue = pick_r ? br.priorityValue : bl.priorityValue;
        wdata_nx.active        = 1'b1;
        end_nx                 = pick_r;
        done_nx                = NEXT_LEVEL;
      end
    end
`ifdef PHEAP_OVF_DETECT_EN
    if (ovf) done_nx = DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= LEQ;
      in_q     <= '0;
      pos_q    <= '0;
      wdata_q  <= '0;
      done_q   <= DONE;
      out_q    <= '0;
      posout_q <= '0;
    end else begin
      if (take) begin
        op_q  <= lv.op;
        in_q  <= lv.in;
        pos_q <= lv.posIn;
      end
      if (state == READ) begin
        wdata_q  <= wdata_nx;
        done_q   <= done_nx;
        out_q    <= out_nx;
        posout_q <= {pos_q, end_nx};
      end
    end
  end
endmodule

// File: tb/tb_pheap_level.sv
// Directed bench: level 2 of a 3-level heap, plus a bottom level (LEVEL=3, LAST=1).
module tb_pheap_level;
  import pheap_level_pkg::*;

`ifdef PHEAP_OVF_DETECT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pheap_level_if #(.LEVEL(2)) b2();
  pheap_level_if #(.LEVEL(3)) b3();

  pheap_level #(.LEVEL(2), .LAST(1'b0)) dut      (.clk(clk), .rst(rst), .lv(b2.slave));
  pheap_level #(.LEVEL(3), .LAST(1'b1)) dut_last (.clk(clk), .rst(rst), .lv(b3.slave));

  int n_chk  = 0;
  int n_fail = 0;
  done_t rd_done;
  logic  rd_raddr;

  function automatic entry_t mk(input logic [31:0] p, input logic [LEVELS-1:0] c, input logic a);
    mk = '{priorityValue: p, capacity: c, active: a};
  endfunction

  // Leaves the bench one #1 into the EXEC cycle; READ-cycle status returned via outputs.
  task automatic issue2(input opcode_t op, input logic [31:0] v, input logic pos,
                        input entry_t bl, input entry_t br,
                        output done_t rdone, output logic rraddr);
    @(posedge clk); #1;
    b2.start = 1'b1; b2.op = op; b2.in = v; b2.posIn = pos; b2.rBotL = bl; b2.rBotR = br;
    @(posedge clk); #1;
    b2.start = 1'b0;
    rdone  = b2.done;
    rraddr = b2.raddrBot;
    @(posedge clk); #1;
  endtask

  task automatic issue3(input opcode_t op, input logic [31:0] v, input logic [1:0] pos,
                        input entry_t bl, input entry_t br);
    @(posedge clk); #1;
    b3.start = 1'b1; b3.op = op; b3.in = v; b3.posIn = pos; b3.rBotL = bl; b3.rBotR = br;
    @(posedge clk); #1;
    b3.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    b2.start = 1'b0; b2.op = LEQ; b2.in = '0; b2.posIn = '0; b2.raddrTop = '0;
    b2.rBotL = '0; b2.rBotR = '0;
    b3.start = 1'b0; b3.op = LEQ; b3.in = '0; b3.posIn = '0; b3.raddrTop = '0;
    b3.rBotL = '0; b3.rBotR = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    if (b2.rTopL !== mk(0, 3, 0)) begin $display("FAIL reset_rTopL: got %h want %h", b2.rTopL, mk(0, 3, 0)); n_fail++; end n_chk++;
    if (b2.rTopR !== mk(0, 3, 0)) begin $display("FAIL reset_rTopR: got %h want %h", b2.rTopR, mk(0, 3, 0)); n_fail++; end n_chk++;
    if (b2.done !== DONE) begin $display("FAIL reset_done: got %0d want %0d", b2.done, DONE); n_fail++; end n_chk++;
    if (b2.err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", b2.err); n_fail++; end n_chk++;
    if (b2.out !== 32'd0 || b2.posOut !== 2'b00 || b2.raddrBot !== 1'b0) begin
      $display("FAIL reset_outs: got out=%0d posOut=%b raddrBot=%b want 0/00/0", b2.out, b2.posOut, b2.raddrBot); n_fail++; end n_chk++;
    if (b3.rTopL !== mk(0, 1, 0)) begin $display("FAIL reset_last_rTopL: got %h want %h", b3.rTopL, mk(0, 1, 0)); n_fail++; end n_chk++;
  endtask

  task automatic test_leq_empty();
    issue2(LEQ, 50, 1'b0, '0, '0, rd_done, rd_raddr);
    if (rd_done !== WAIT) begin $display("FAIL leq_empty_read_wait: got %0d want %0d", rd_done, WAIT); n_fail++; end n_chk++;
    if (b2.done !== DONE) begin $display("FAIL leq_empty_done: got %0d want %0d", b2.done, DONE); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopL !== mk(50, 2, 1)) begin $display("FAIL leq_empty_slot0: got %h want %h", b2.rTopL, mk(50, 2, 1)); n_fail++; end n_chk++;
    if (b2.rTopR !== mk(0, 3, 0)) begin $display("FAIL leq_empty_slot1: got %h want %h", b2.rTopR, mk(0, 3, 0)); n_fail++; end n_chk++;
  endtask

  task automatic test_leq_push();
    issue2(LEQ, 70, 1'b0, mk(5, 1, 1), mk(9, 1, 1), rd_done, rd_raddr);
    if (b2.done !== NEXT_LEVEL) begin $display("FAIL leq_push_done: got %0d want %0d", b2.done, NEXT_LEVEL); n_fail++; end n_chk++;
    if (b2.out !== 32'd50) begin $display("FAIL leq_push_out: got %0d want 50", b2.out); n_fail++; end n_chk++;
    if (b2.posOut !== 2'b00) begin $display("FAIL leq_push_posOut: got %b want 00", b2.posOut); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopL !== mk(70, 1, 1)) begin $display("FAIL leq_push_slot0: got %h want %h", b2.rTopL, mk(70, 1, 1)); n_fail++; end n_chk++;
    if (b2.done !== DONE || b2.out !== 32'd50) begin
      $display("FAIL leq_push_hold: got done=%0d out=%0d want %0d/50", b2.done, b2.out, DONE); n_fail++; end n_chk++;
  endtask

  task automatic test_leq_tie_right();
    issue2(LEQ, 30, 1'b1, '0, '0, rd_done, rd_raddr);
    @(posedge clk); #1;
    if (b2.rTopR !== mk(30, 2, 1)) begin $display("FAIL leq_fill1: got %h want %h", b2.rTopR, mk(30, 2, 1)); n_fail++; end n_chk++;
    issue2(LEQ, 30, 1'b1, mk(8, 2, 1), mk(4, 2, 1), rd_done, rd_raddr);
    if (rd_raddr !== 1'b1) begin $display("FAIL leq_tie_raddrBot: got %b want 1", rd_raddr); n_fail++; end n_chk++;
    if (b2.done !== NEXT_LEVEL || b2.out !== 32'd30 || b2.posOut !== 2'b11) begin
      $display("FAIL leq_tie_exec: got done=%0d out=%0d posOut=%b want %0d/30/11", b2.done, b2.out, b2.posOut, NEXT_LEVEL); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopR !== mk(30, 1, 1)) begin $display("FAIL leq_tie_slot1: got %h want %h", b2.rTopR, mk(30, 1, 1)); n_fail++; end n_chk++;
  endtask

  task automatic test_leq_cap_bounds();
    issue2(LEQ, 100, 1'b1, mk(1, 0, 1), mk(2, 1, 1), rd_done, rd_raddr);
    if (b2.done !== NEXT_LEVEL || b2.out !== 32'd30 || b2.posOut !== 2'b11) begin
      $display("FAIL leq_lcap0_exec: got done=%0d out=%0d posOut=%b want %0d/30/11", b2.done, b2.out, b2.posOut, NEXT_LEVEL); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopR !== mk(100, 0, 1)) begin $display("FAIL leq_lcap0_slot1: got %h want %h", b2.rTopR, mk(100, 0, 1)); n_fail++; end n_chk++;
    issue2(LEQ, 10, 1'b1, mk(0, 3, 0), mk(0, 0, 0), rd_done, rd_raddr);
    if (b2.done !== (OVF ? DONE : NEXT_LEVEL)) begin
      $display("FAIL leq_full_done: got %0d want %0d", b2.done, OVF ? DONE : NEXT_LEVEL); n_fail++; end n_chk++;
    if (b2.out !== 32'd10 || b2.posOut !== 2'b10) begin
      $display("FAIL leq_full_out: got out=%0d posOut=%b want 10/10", b2.out, b2.posOut); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopR !== mk(100, 0, 1)) begin $display("FAIL leq_full_satdec: got %h want %h", b2.rTopR, mk(100, 0, 1)); n_fail++; end n_chk++;
  endtask

  task automatic test_deq();
    issue2(DEQ, 0, 1'b0, mk(40, 0, 1), mk(60, 0, 1), rd_done, rd_raddr);
    if (b2.done !== NEXT_LEVEL || b2.out !== 32'd70 || b2.posOut !== 2'b01) begin
      $display("FAIL deq_right_exec: got done=%0d out=%0d posOut=%b want %0d/70/01", b2.done, b2.out, b2.posOut, NEXT_LEVEL); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopL !== mk(60, 2, 1)) begin $display("FAIL deq_right_slot0: got %h want %h", b2.rTopL, mk(60, 2, 1)); n_fail++; end n_chk++;
    issue2(DEQ, 0, 1'b0, mk(20, 0, 1), mk(20, 0, 1), rd_done, rd_raddr);
    if (b2.done !== NEXT_LEVEL || b2.out !== 32'd60 || b2.posOut !== 2'b00) begin
      $display("FAIL deq_tie_exec: got done=%0d out=%0d posOut=%b want %0d/60/00", b2.done, b2.out, b2.posOut, NEXT_LEVEL); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopL !== mk(20, 3, 1)) begin $display("FAIL deq_tie_slot0: got %h want %h", b2.rTopL, mk(20, 3, 1)); n_fail++; end n_chk++;
    issue2(DEQ, 0, 1'b0, mk(5, 1, 0), mk(6, 1, 0), rd_done, rd_raddr);
    if (b2.done !== DONE || b2.out !== 32'd20) begin
      $display("FAIL deq_leaf_exec: got done=%0d out=%0d want %0d/20", b2.done, b2.out, DONE); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopL !== mk(0, 3, 0)) begin $display("FAIL deq_leaf_capsat: got %h want %h", b2.rTopL, mk(0, 3, 0)); n_fail++; end n_chk++;
  endtask

  task automatic test_deq_right_only();
    issue2(DEQ, 0, 1'b1, mk(99, 0, 0), mk(7, 0, 1), rd_done, rd_raddr);
    if (b2.done !== NEXT_LEVEL || b2.out !== 32'd100 || b2.posOut !== 2'b11) begin
      $display("FAIL deq_ronly_exec: got done=%0d out=%0d posOut=%b want %0d/100/11", b2.done, b2.out, b2.posOut, NEXT_LEVEL); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopR !== mk(7, 1, 1)) begin $display("FAIL deq_ronly_slot1: got %h want %h", b2.rTopR, mk(7, 1, 1)); n_fail++; end n_chk++;
  endtask

  task automatic test_collision();
    issue2(DEQ, 0, 1'b1, '0, '0, rd_done, rd_raddr);
    if (b2.rTopR !== mk(7, 1, 1)) begin $display("FAIL coll_pre_write: got %h want %h", b2.rTopR, mk(7, 1, 1)); n_fail++; end n_chk++;
    if (b2.done !== DONE || b2.out !== 32'd7) begin
      $display("FAIL coll_exec: got done=%0d out=%0d want %0d/7", b2.done, b2.out, DONE); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b2.rTopR !== mk(0, 2, 0)) begin $display("FAIL coll_fwd_rTopR: got %h want %h", b2.rTopR, mk(0, 2, 0)); n_fail++; end n_chk++;
    if (b2.rTopL !== mk(0, 3, 0)) begin $display("FAIL coll_rTopL: got %h want %h", b2.rTopL, mk(0, 3, 0)); n_fail++; end n_chk++;
  endtask

  task automatic test_last_level();
    issue3(LEQ, 5, 2'd0, mk(50, 1, 1), mk(50, 1, 1));
    if (b3.done !== DONE) begin $display("FAIL last_fill_done: got %0d want %0d", b3.done, DONE); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b3.rTopL !== mk(5, 0, 1)) begin $display("FAIL last_fill_slot: got %h want %h", b3.rTopL, mk(5, 0, 1)); n_fail++; end n_chk++;
    if (b3.err !== 1'b0) begin $display("FAIL last_fill_err: got %b want 0", b3.err); n_fail++; end n_chk++;
    issue3(LEQ, 9, 2'd0, mk(50, 1, 1), mk(50, 1, 1));
    if (b3.done !== DONE || b3.out !== 32'd5) begin
      $display("FAIL last_full_exec: got done=%0d out=%0d want %0d/5", b3.done, b3.out, DONE); n_fail++; end n_chk++;
    if (b3.err !== OVF) begin $display("FAIL last_full_err: got %b want %b", b3.err, OVF); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b3.rTopL !== mk(9, 0, 1)) begin $display("FAIL last_full_keepmax: got %h want %h", b3.rTopL, mk(9, 0, 1)); n_fail++; end n_chk++;
    issue3(DEQ, 0, 2'd0, mk(50, 1, 1), mk(50, 1, 1));
    if (b3.done !== DONE || b3.out !== 32'd9) begin
      $display("FAIL last_deq_exec: got done=%0d out=%0d want %0d/9", b3.done, b3.out, DONE); n_fail++; end n_chk++;
    @(posedge clk); #1;
    if (b3.rTopL !== mk(0, 1, 0)) begin $display("FAIL last_deq_slot: got %h want %h", b3.rTopL, mk(0, 1, 0)); n_fail++; end n_chk++;
    if (b3.err !== OVF) begin $display("FAIL last_err_sticky: got %b want %b", b3.err, OVF); n_fail++; end n_chk++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (b3.err !== 1'b0) begin $display("FAIL last_rst_clears_err: got %b want 0", b3.err); n_fail++; end n_chk++;
  endtask

  initial begin
    test_reset();
    test_leq_empty();
    test_leq_push();
    test_leq_tie_right();
    test_leq_cap_bounds();
    test_deq();
    test_deq_right_only();
    test_collision();
    test_last_level();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
